sram_like_bridge: RTL and testbench
===================================

# sram_like_bridge

Parametrised CPU-port-to-sram-like bridge. It converts the core's single-cycle SRAM port (en/wen/addr/wdata/rdata) into the split-handshake sram-like bus (req/addr_ok/data_ok). It stalls the pipeline while a transaction is outstanding and holds read data until the whole pipeline can advance. One instance sits on the instruction port and one on the data port, between the core and the bus/AXI adapter; each instance's `cpu_stall` feeds the sibling's `ext_stall`.

## Interface

Parameters:
- `DATA_W`, 32: data width; must be 32 or 64. `BYTES = DATA_W/8`.
- `ADDR_W`, 32: address width.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `cpu_en`, in, 1: access request.
- `cpu_wen`, in, `BYTES`: byte write enables; 0 means read.
- `cpu_addr`, in, `ADDR_W`: byte address.
- `cpu_wdata`, in, `DATA_W`: write data.
- `cpu_flush`, in, 1: pipeline flush (exception) for this access.
- `ext_stall`, in, 1: stall from the sibling port or other pipeline source.
- `cpu_rdata`, out, `DATA_W`: read data, valid while `cpu_stall` = 0 after a read.
- `cpu_stall`, out, 1: stall request to the pipeline.
- `bus_req`, out, 1: sram-like request.
- `bus_wr`, out, 1: 1 = write.
- `bus_size`, out, 2: log2 of the byte count.
- `bus_addr`, out, `ADDR_W`: request address.
- `bus_wstrb`, out, `BYTES`: byte strobes, equal to the latched `cpu_wen`.
- `bus_wdata`, out, `DATA_W`: write data.
- `bus_addr_ok`, in, 1: request accepted.
- `bus_data_ok`, in, 1: response done; `bus_rdata` valid.
- `bus_rdata`, in, `DATA_W`: read data.

## Operation

States: IDLE, REQ, WAIT, DONE, DRAIN. All `bus_*` outputs are registered from a request latch captured on IDLE→REQ.

- **IDLE**
  - `cpu_en` = 1 and `cpu_flush` = 0: latch wen/addr/wdata, go to REQ.
  - `cpu_flush` = 1: no request is issued.
- **REQ**
  - `bus_req` = 1, held with all request fields stable until `bus_addr_ok` = 1.
  - On `bus_addr_ok` = 1, go to WAIT. If `cpu_flush` was seen during REQ or in this cycle, go to DRAIN instead.
  - A request is never withdrawn.
- **WAIT**
  - On `bus_data_ok` = 1, capture `bus_rdata` into the hold register and go to DONE.
  - If `cpu_flush` = 1 arrives in WAIT before `data_ok`, go to DRAIN.
  - `bus_data_ok` is ignored in REQ and IDLE; the bus never returns data in the `addr_ok` cycle.
- **DRAIN**
  - Waits for `bus_data_ok`, discards the data, then goes to IDLE.
  - `cpu_stall` = 0 (the flushed instruction is dead).
  - A new `cpu_en` is not accepted until IDLE is re-entered.
- **DONE**
  - `cpu_stall` = 0; `cpu_rdata` = hold register.
  - `ext_stall` = 0: go to IDLE (the pipeline advances this cycle).
  - `ext_stall` = 1: stay in DONE with rdata held. A new request is not re-issued.
- **cpu_stall** (combinational) = `cpu_en` & ~`cpu_flush` & (state ∈ {IDLE, REQ, WAIT}).
- **bus_size / bus_addr rules**
  - Read: `bus_size` = log2(`BYTES`); `bus_addr` = `cpu_addr` with the low log2(`BYTES`) bits cleared; `bus_wstrb` = 0.
  - Write: popcount(wen) 1/2/4/8 → `bus_size` 0/1/2/3, and `bus_addr` low bits = index of the lowest set strobe.
  - Any other write pattern (e.g. 0111): `bus_size` = log2(`BYTES`), aligned address; strobes still qualify the bytes.
- **Reset** (async, `resetn` = 0): state = IDLE; `bus_req` = 0; `bus_wr` = 0; `bus_size` = 0; `bus_addr`, `bus_wstrb`, `bus_wdata` = 0; hold register = 0; `cpu_rdata` = 0; `cpu_stall` = 0 while `cpu_en` = 0.
  - Reset mid-transaction abandons it. The bus side is reset by the same `resetn`.

## Timing

- **Minimum read latency:** `cpu_en` in cycle 0, `bus_req` in cycle 1 with `addr_ok`, `data_ok` in cycle 2, DONE in cycle 3. `cpu_stall` = 1 in cycles 0–2 and 0 in cycle 3.
- Each `bus_addr_ok` wait cycle and each `bus_data_ok` wait cycle adds one stall cycle.
- At most one outstanding transaction; there is no back-to-back issue. The next request's `bus_req` is at the earliest 2 cycles after DONE is exited.
- `cpu_rdata` is stable from DONE entry until DONE exit, across any number of `ext_stall` cycles.
- **Simultaneous events:**
  - `bus_addr_ok` and `cpu_flush` in the same REQ cycle: go to DRAIN.
  - `bus_data_ok` and `cpu_flush` in the same WAIT cycle: go to DONE. The flush is ignored because the data already arrived; the pipeline discards it.

## Test plan

1. **Read, zero wait:** addr 0x1000_0004, `addr_ok` in first REQ cycle, `data_ok` next cycle with 0xDEAD_BEEF → `bus_addr` = 0x1000_0004, `bus_size` = 2, `bus_wr` = 0; stall for 3 cycles; `cpu_rdata` = 0xDEAD_BEEF in cycle 3.
2. **Byte write:** wen = 0100, addr 0x2000_0000, wdata 0x00AB_0000 → `bus_wr` = 1, `bus_size` = 0, `bus_addr` = 0x2000_0002, `bus_wstrb` = 0100. `bus_req` is held 4 cycles until `addr_ok`, with fields stable.
3. **Sibling stall:** read completes with `ext_stall` = 1 for 5 cycles → DONE held, `cpu_stall` = 0, `cpu_rdata` constant, no second `bus_req`. IDLE follows the cycle `ext_stall` falls.
4. **Flush in WAIT:** `cpu_flush` pulse while waiting → `cpu_stall` drops next cycle. The late `data_ok` (0x1234_5678) is swallowed and `cpu_rdata` is unchanged. The following request issues only after `data_ok`.
5. **`DATA_W` = 64:** half-word write with wen = 0011_0000 at 0x...00 → `bus_size` = 1, `bus_addr` low bits = 4. A read returns 64-bit data intact.
6. **Reset mid-REQ:** `resetn` low asynchronously → `bus_req` = 0 immediately without a clock edge; state IDLE, `cpu_rdata` = 0.

Source files
------------

// File: rtl/sram_like_bridge.sv
// Bridges a single-cycle CPU SRAM port onto the split req/addr_ok/data_ok bus.
// One outstanding transaction; read data is held until the pipeline advances.
module sram_like_bridge #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_flush,
  input  logic                ext_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DONE, DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic                flush_q, flush_d;
  logic [DATA_W-1:0]   hold_q;
  logic                req_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BYTES-1:0]    wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                accept;
  logic                cap;
  logic [3:0]          pop;
  logic [LSB-1:0]      low;
  logic                pow2;
  logic [ADDR_W-1:0]   addr_al;
  logic [1:0]          size_d;
  logic [ADDR_W-1:0]   addr_d;

  // Downward scan leaves low at the lowest set strobe.
  always_comb begin
    pop = '0;
    low = '0;
    for (int i = BYTES - 1; i >= 0; i--) begin
      if (cpu_wen[i]) begin
        pop = pop + 4'd1;
        low = LSB'(i);
      end
    end
    pow2 = (pop == 4'd1) | (pop == 4'd2)
         | (pop == 4'd4) | (pop == 4'd8);
    addr_al = cpu_addr & ~ADDR_W'(BYTES - 1);
    size_d  = 2'(LSB);
    addr_d  = addr_al;
    if ((|cpu_wen) && pow2) begin
      size_d = (pop == 4'd1) ? 2'd0 :
               (pop == 4'd2) ? 2'd1 :
               (pop == 4'd4) ? 2'd2 : 2'd3;
      addr_d = addr_al | ADDR_W'(low);
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    accept  = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_en && !cpu_flush) begin
          accept  = 1'b1;
          flush_d = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cpu_flush) flush_d = 1'b1;
        if (bus_addr_ok) begin
          state_d = (flush_q || cpu_flush) ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          cap     = 1'b1;
          state_d = DONE;
        end else if (cpu_flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (!ext_stall) state_d = IDLE;
      end
      DRAIN: begin
        if (bus_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      flush_q <= 1'b0;
      hold_q  <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      if (accept) begin
        req_q   <= 1'b1;
        wr_q    <= |cpu_wen;
        size_q  <= size_d;
        addr_q  <= addr_d;
        wstrb_q <= cpu_wen;
        wdata_q <= cpu_wdata;
      end else if (state_q == REQ && bus_addr_ok) begin
        req_q   <= 1'b0;
      end
      if (cap) hold_q <= bus_rdata;
    end
  end

  assign cpu_stall = cpu_en & ~cpu_flush
                   & ((state_q == IDLE) | (state_q == REQ)
                    | (state_q == WAIT));
  assign cpu_rdata = hold_q;
  assign bus_req   = req_q;
  assign bus_wr    = wr_q;
  assign bus_size  = size_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: 32-bit and 64-bit instances,
// bus side driven by hand, expectations hand-computed.
module tb_sram_like_bridge;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        en, flush, xst, aok, dok;
  logic [3:0]  wen;
  logic [31:0] addr, wdata, brd;
  logic [31:0] rd, ba, bw;
  logic        st, req, wr;
  logic [1:0]  sz;
  logic [3:0]  bs;

  logic        en64, flush64, xst64, aok64, dok64;
  logic [7:0]  wen64;
  logic [31:0] addr64;
  logic [63:0] wdata64, brd64, rd64, bw64;
  logic [31:0] ba64;
  logic        st64, req64, wr64;
  logic [1:0]  sz64;
  logic [7:0]  bs64;

  int total = 0;
  int bad = 0;

  sram_like_bridge #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .resetn(resetn),
    .cpu_en(en), .cpu_wen(wen), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_flush(flush), .ext_stall(xst),
    .cpu_rdata(rd), .cpu_stall(st),
    .bus_req(req), .bus_wr(wr), .bus_size(sz),
    .bus_addr(ba), .bus_wstrb(bs), .bus_wdata(bw),
    .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata(brd)
  );

  sram_like_bridge #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .resetn(resetn),
    .cpu_en(en64), .cpu_wen(wen64), .cpu_addr(addr64),
    .cpu_wdata(wdata64), .cpu_flush(flush64),
    .ext_stall(xst64),
    .cpu_rdata(rd64), .cpu_stall(st64),
    .bus_req(req64), .bus_wr(wr64), .bus_size(sz64),
    .bus_addr(ba64), .bus_wstrb(bs64), .bus_wdata(bw64),
    .bus_addr_ok(aok64), .bus_data_ok(dok64),
    .bus_rdata(brd64)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b1;
    en = 0; flush = 0; xst = 0; aok = 0; dok = 0;
    wen = 0; addr = 0; wdata = 0; brd = 0;
    en64 = 0; flush64 = 0; xst64 = 0; aok64 = 0; dok64 = 0;
    wen64 = 0; addr64 = 0; wdata64 = 0; brd64 = 0;
    #1 resetn = 1'b0;
    #1;
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_size", 64'(sz), 64'd0);
    chk("rst_addr", 64'(ba), 64'd0);
    chk("rst_wstrb", 64'(bs), 64'd0);
    chk("rst_wdata", 64'(bw), 64'd0);
    chk("rst_rdata", 64'(rd), 64'd0);
    chk("rst_stall", 64'(st), 64'd0);
    chk("rst_req64", 64'(req64), 64'd0);
    cyc();
    cyc();
    resetn = 1'b1;

    // read, zero wait
    en = 1; wen = 0; addr = 32'h1000_0004; #1;
    chk("t1_stall_c0", 64'(st), 64'd1);
    chk("t1_req_c0", 64'(req), 64'd0);
    cyc();
    aok = 1; #1;
    chk("t1_req", 64'(req), 64'd1);
    chk("t1_addr", 64'(ba), 64'h1000_0004);
    chk("t1_size", 64'(sz), 64'd2);
    chk("t1_wr", 64'(wr), 64'd0);
    chk("t1_wstrb", 64'(bs), 64'd0);
    chk("t1_stall_c1", 64'(st), 64'd1);
    cyc();
    aok = 0; dok = 1; brd = 32'hDEAD_BEEF; #1;
    chk("t1_stall_c2", 64'(st), 64'd1);
    chk("t1_req_c2", 64'(req), 64'd0);
    cyc();
    dok = 0; brd = 0; #1;
    chk("t1_stall_c3", 64'(st), 64'd0);
    chk("t1_rdata", 64'(rd), 64'hDEAD_BEEF);
    cyc();
    en = 0; #1;
    chk("t1_idle_req", 64'(req), 64'd0);

    // byte write, addr_ok after 4 request cycles
    en = 1; wen = 4'b0100; addr = 32'h2000_0000;
    wdata = 32'h00AB_0000; #1;
    chk("t2_stall_c0", 64'(st), 64'd1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      aok = (k == 3); #1;
      chk("t2_req", 64'(req), 64'd1);
      chk("t2_addr", 64'(ba), 64'h2000_0002);
      chk("t2_size", 64'(sz), 64'd0);
      chk("t2_wr", 64'(wr), 64'd1);
      chk("t2_wstrb", 64'(bs), 64'b0100);
      chk("t2_wdata", 64'(bw), 64'h00AB_0000);
      chk("t2_stall", 64'(st), 64'd1);
      cyc();
    end
    aok = 0; dok = 1; #1;
    chk("t2_wait_req", 64'(req), 64'd0);
    chk("t2_wait_stall", 64'(st), 64'd1);
    cyc();
    dok = 0; #1;
    chk("t2_done_stall", 64'(st), 64'd0);
    cyc();
    en = 0; wen = 0; wdata = 0; #1;

    // sibling stall holds DONE
    en = 1; addr = 32'h3000_0008; #1;
    cyc();
    aok = 1; #1;
    chk("t3_addr", 64'(ba), 64'h3000_0008);
    cyc();
    aok = 0; dok = 1; brd = 32'hCAFE_F00D; #1;
    cyc();
    dok = 0; brd = 0; xst = 1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t3_hold_stall", 64'(st), 64'd0);
      chk("t3_hold_rdata", 64'(rd), 64'hCAFE_F00D);
      chk("t3_hold_noreq", 64'(req), 64'd0);
      cyc();
    end
    xst = 0; #1;
    chk("t3_fall_rdata", 64'(rd), 64'hCAFE_F00D);
    chk("t3_fall_stall", 64'(st), 64'd0);
    cyc();
    addr = 32'h4000_0000; #1;
    chk("t3_idle_stall", 64'(st), 64'd1);
    chk("t3_idle_noreq", 64'(req), 64'd0);
    cyc();

    // flush in WAIT, late data_ok swallowed
    aok = 1; #1;
    chk("t4_req", 64'(req), 64'd1);
    chk("t4_addr", 64'(ba), 64'h4000_0000);
    cyc();
    aok = 0; flush = 1; #1;
    chk("t4_flush_stall", 64'(st), 64'd0);
    cyc();
    flush = 0; addr = 32'h5000_0000; #1;
    chk("t4_drain_stall", 64'(st), 64'd0);
    chk("t4_drain_req", 64'(req), 64'd0);
    cyc();
    #1;
    chk("t4_drain2_stall", 64'(st), 64'd0);
    chk("t4_drain2_req", 64'(req), 64'd0);
    cyc();
    dok = 1; brd = 32'h1234_5678; #1;
    chk("t4_late_rdata", 64'(rd), 64'hCAFE_F00D);
    cyc();
    dok = 0; brd = 0; #1;
    chk("t4_after_rdata", 64'(rd), 64'hCAFE_F00D);
    chk("t4_after_stall", 64'(st), 64'd1);
    chk("t4_after_noreq", 64'(req), 64'd0);
    cyc();
    aok = 1; #1;
    chk("t4_next_req", 64'(req), 64'd1);
    chk("t4_next_addr", 64'(ba), 64'h5000_0000);
    cyc();

    // data_ok and flush together in WAIT
    aok = 0; dok = 1; flush = 1; brd = 32'h0BAD_F00D; #1;
    cyc();
    dok = 0; flush = 0; brd = 0; #1;
    chk("t5_rdata", 64'(rd), 64'h0BAD_F00D);
    chk("t5_stall", 64'(st), 64'd0);
    cyc();
    en = 0; #1;

    // flush in REQ, then addr_ok -> drain
    en = 1; addr = 32'h6000_0000; #1;
    cyc();
    flush = 1; #1;
    chk("t6_flush_stall", 64'(st), 64'd0);
    cyc();
    flush = 0; aok = 1; #1;
    chk("t6_req_held", 64'(req), 64'd1);
    cyc();
    aok = 0; addr = 32'h7000_0000; #1;
    chk("t6_drain_stall", 64'(st), 64'd0);
    dok = 1; brd = 32'hFFFF_FFFF; #1;
    cyc();
    dok = 0; brd = 0; #1;
    chk("t6_rdata", 64'(rd), 64'h0BAD_F00D);
    chk("t6_idle_stall", 64'(st), 64'd1);
    cyc();
    #1;
    chk("t6_req", 64'(req), 64'd1);
    chk("t6_addr", 64'(ba), 64'h7000_0000);

    // asynchronous reset mid-REQ
    resetn = 0; #1;
    chk("t7_req", 64'(req), 64'd0);
    chk("t7_rdata", 64'(rd), 64'd0);
    chk("t7_addr", 64'(ba), 64'd0);
    en = 0; #1;
    chk("t7_stall", 64'(st), 64'd0);
    cyc();
    resetn = 1;
    cyc();

    // irregular write pattern -> full-width, aligned
    en = 1; wen = 4'b0111; addr = 32'h2000_0003; #1;
    cyc();
    #1;
    chk("t8_size", 64'(sz), 64'd2);
    chk("t8_addr", 64'(ba), 64'h2000_0000);
    chk("t8_wstrb", 64'(bs), 64'b0111);
    aok = 1; #1;
    cyc();
    aok = 0; dok = 1; #1;
    cyc();
    dok = 0; en = 0; wen = 0; #1;
    cyc();

    // 64-bit half-word write then read
    en64 = 1; wen64 = 8'b0011_0000; addr64 = 32'h8000_0000;
    wdata64 = 64'h0000_BEEF_0000_0000; #1;
    chk("t9_stall", 64'(st64), 64'd1);
    cyc();
    #1;
    chk("t9_req", 64'(req64), 64'd1);
    chk("t9_size", 64'(sz64), 64'd1);
    chk("t9_addr", 64'(ba64), 64'h8000_0004);
    chk("t9_wstrb", 64'(bs64), 64'h30);
    chk("t9_wr", 64'(wr64), 64'd1);
    chk("t9_wdata", bw64, 64'h0000_BEEF_0000_0000);
    aok64 = 1; #1;
    cyc();
    aok64 = 0; dok64 = 1; #1;
    cyc();
    dok64 = 0; #1;
    chk("t9_done_stall", 64'(st64), 64'd0);
    cyc();
    en64 = 0; wen64 = 0; #1;
    en64 = 1; addr64 = 32'h8000_000C; #1;
    cyc();
    #1;
    chk("t10_addr", 64'(ba64), 64'h8000_0008);
    chk("t10_size", 64'(sz64), 64'd3);
    chk("t10_wr", 64'(wr64), 64'd0);
    aok64 = 1; #1;
    cyc();
    aok64 = 0; dok64 = 1;
    brd64 = 64'h0123_4567_89AB_CDEF; #1;
    cyc();
    dok64 = 0; brd64 = 0; #1;
    chk("t10_rdata", rd64, 64'h0123_4567_89AB_CDEF);
    chk("t10_stall", 64'(st64), 64'd0);
    cyc();
    en64 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
